// File: rtl/mem_access_stage.sv
// MEM pipeline stage: registers EX results, runs data-memory loads/stores over a
// req/ack handshake, stalls upstream while busy and flags misaligned or timed-out accesses.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  EX_FUNC3,
  input  logic        EX_WRITE_ENABLE,
  input  logic        EX_DATA_MEM_SELECT,
  input  logic        EX_MEM_WRITE,
  input  logic [31:0] EX_ALU_RESULT,
  input  logic [31:0] EX_JAL_SELECTED,
  input  logic [31:0] EX_RS2_DATA,
  input  logic [4:0]  EX_RD,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        MEM_STALL,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  output logic [2:0]  MEM_FUNC3,
  output logic        MEM_WRITE_ENABLE,
  output logic        MEM_DATA_MEM_SELECT,
  output logic [31:0] MEM_JAL_SELECTED,
  output logic [31:0] MEM_DATA_OUT,
  output logic [4:0]  MEM_RD,
  output logic        MEM_FAULT
);

  localparam int CW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          pending_we_q;
  logic          load_q;
  logic [1:0]    off_q;

  logic          mem_op_d;
  logic          misaligned_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;

  assign MEM_STALL = (state_q == BUSY);
  assign DMEM_REQ  = (state_q == BUSY);

  always_comb begin
    mem_op_d     = EX_DATA_MEM_SELECT | EX_MEM_WRITE;
    misaligned_d = 1'b0;
    be_d         = 4'b1111;
    wdata_d      = EX_RS2_DATA;
    case (EX_FUNC3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << EX_ALU_RESULT[1:0];
        wdata_d = {4{EX_RS2_DATA[7:0]}};
      end
      2'b01: begin
        misaligned_d = EX_ALU_RESULT[0];
        be_d         = 4'b0011 << EX_ALU_RESULT[1:0];
        wdata_d      = {2{EX_RS2_DATA[15:0]}};
      end
      default: misaligned_d = |EX_ALU_RESULT[1:0];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      pending_we_q        <= 1'b0;
      load_q              <= 1'b0;
      off_q               <= 2'b00;
      DMEM_WE             <= 1'b0;
      DMEM_ADDR           <= '0;
      DMEM_BE             <= '0;
      DMEM_WDATA          <= '0;
      MEM_FUNC3           <= '0;
      MEM_WRITE_ENABLE    <= 1'b0;
      MEM_DATA_MEM_SELECT <= 1'b0;
      MEM_JAL_SELECTED    <= '0;
      MEM_DATA_OUT        <= '0;
      MEM_RD              <= '0;
      MEM_FAULT           <= 1'b0;
    end else begin
      MEM_FAULT <= 1'b0;
      case (state_q)
        IDLE: begin
          MEM_FUNC3           <= EX_FUNC3;
          MEM_DATA_MEM_SELECT <= EX_DATA_MEM_SELECT;
          MEM_JAL_SELECTED    <= EX_JAL_SELECTED;
          MEM_RD              <= EX_RD;
          if (!mem_op_d) begin
            MEM_WRITE_ENABLE <= EX_WRITE_ENABLE;
          end else begin
            // Writeback stays off until the access finishes, so WB never sees stale data.
            MEM_WRITE_ENABLE <= 1'b0;
            if (misaligned_d) begin
              MEM_FAULT <= 1'b1;
            end else begin
              state_q      <= BUSY;
              cnt_q        <= '0;
              pending_we_q <= EX_WRITE_ENABLE;
              load_q       <= EX_DATA_MEM_SELECT & ~EX_MEM_WRITE;
              off_q        <= EX_ALU_RESULT[1:0];
              DMEM_WE      <= EX_MEM_WRITE;
              DMEM_ADDR    <= {EX_ALU_RESULT[31:2], 2'b00};
              DMEM_BE      <= be_d;
              DMEM_WDATA   <= wdata_d;
            end
          end
        end
        BUSY: begin
          if (DMEM_ACK) begin
            if (load_q) MEM_DATA_OUT <= DMEM_RDATA >> {off_q, 3'b000};
            MEM_WRITE_ENABLE <= pending_we_q;
            state_q          <= IDLE;
          end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
            MEM_FAULT        <= 1'b1;
            MEM_WRITE_ENABLE <= 1'b0;
            state_q          <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level model sets the expected
// outputs per cycle, a negedge process compares them, plus literal spot checks.
module tb_mem_access_stage;
  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  EX_FUNC3;
  logic        EX_WRITE_ENABLE, EX_DATA_MEM_SELECT, EX_MEM_WRITE;
  logic [31:0] EX_ALU_RESULT, EX_JAL_SELECTED, EX_RS2_DATA;
  logic [4:0]  EX_RD;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_ACK;
  logic        MEM_STALL, DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic [2:0]  MEM_FUNC3;
  logic        MEM_WRITE_ENABLE, MEM_DATA_MEM_SELECT, MEM_FAULT;
  logic [31:0] MEM_JAL_SELECTED, MEM_DATA_OUT;
  logic [4:0]  MEM_RD;

  always #5 CLK = ~CLK;

  mem_access_stage #(.ACK_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .EX_FUNC3(EX_FUNC3), .EX_WRITE_ENABLE(EX_WRITE_ENABLE),
    .EX_DATA_MEM_SELECT(EX_DATA_MEM_SELECT), .EX_MEM_WRITE(EX_MEM_WRITE),
    .EX_ALU_RESULT(EX_ALU_RESULT), .EX_JAL_SELECTED(EX_JAL_SELECTED),
    .EX_RS2_DATA(EX_RS2_DATA), .EX_RD(EX_RD),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .MEM_STALL(MEM_STALL), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE), .DMEM_WDATA(DMEM_WDATA),
    .MEM_FUNC3(MEM_FUNC3), .MEM_WRITE_ENABLE(MEM_WRITE_ENABLE),
    .MEM_DATA_MEM_SELECT(MEM_DATA_MEM_SELECT), .MEM_JAL_SELECTED(MEM_JAL_SELECTED),
    .MEM_DATA_OUT(MEM_DATA_OUT), .MEM_RD(MEM_RD), .MEM_FAULT(MEM_FAULT)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle
  logic        e_stall, e_req, e_fault, e_wen, e_dsel, e_dwe;
  logic [2:0]  e_func3;
  logic [31:0] e_jal, e_dout, e_daddr, e_dwdata;
  logic [4:0]  e_rd;
  logic [3:0]  e_dbe;
  bit          chk_en = 0, chk_dmem = 0, chk_wd = 0;
  logic [31:0] m_dout;

  // Snapshots of the first busy cycle of the last access
  logic [31:0] sn_addr, sn_wd;
  logic [3:0]  sn_be;
  logic        sn_we;
  int          busy_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("stall", {31'b0, MEM_STALL}, {31'b0, e_stall});
      check("req", {31'b0, DMEM_REQ}, {31'b0, e_req});
      check("fault", {31'b0, MEM_FAULT}, {31'b0, e_fault});
      check("wen", {31'b0, MEM_WRITE_ENABLE}, {31'b0, e_wen});
      check("dsel", {31'b0, MEM_DATA_MEM_SELECT}, {31'b0, e_dsel});
      check("func3", {29'b0, MEM_FUNC3}, {29'b0, e_func3});
      check("jal", MEM_JAL_SELECTED, e_jal);
      check("dout", MEM_DATA_OUT, e_dout);
      check("rd", {27'b0, MEM_RD}, {27'b0, e_rd});
      if (chk_dmem) begin
        check("dwe", {31'b0, DMEM_WE}, {31'b0, e_dwe});
        check("daddr", DMEM_ADDR, e_daddr);
        check("dbe", {28'b0, DMEM_BE}, {28'b0, e_dbe});
      end
      if (chk_wd) check("dwdata", DMEM_WDATA, e_dwdata);
    end
  end

  // Access size in bytes from func3
  function automatic int msize(input logic [2:0] f3);
    logic [1:0] w;
    w = f3[1:0];
    if (w == 2'b00) return 1;
    if (w == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic mis(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = msize(f3);
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] mbe(input logic [2:0] f3, input logic [31:0] a);
    int sz, off;
    logic [3:0] r;
    sz  = msize(f3);
    off = (sz == 4) ? 0 : int'(a[1:0]);
    for (int k = 0; k < 4; k++) r[k] = (k >= off) && (k < off + sz);
    return r;
  endfunction

  function automatic logic [31:0] mwd(input logic [2:0] f3, input logic [31:0] rs2);
    int sz;
    logic [31:0] r;
    sz = msize(f3);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = rs2[8*(k % sz) +: 8];
    return r;
  endfunction

  task automatic set_idle();
    e_stall = 0; e_req = 0; chk_dmem = 0; chk_wd = 0;
  endtask

  task automatic do_reset(input int n);
    RST = 1; EX_FUNC3 = 0; EX_WRITE_ENABLE = 0; EX_DATA_MEM_SELECT = 0; EX_MEM_WRITE = 0;
    EX_ALU_RESULT = 0; EX_JAL_SELECTED = 0; EX_RS2_DATA = 0; EX_RD = 0;
    DMEM_RDATA = 0; DMEM_ACK = 0;
    repeat (n) @(posedge CLK);
    #1;
    RST = 0;
    m_dout = 0;
    e_stall = 0; e_req = 0; e_fault = 0; e_wen = 0; e_dsel = 0; e_func3 = 0;
    e_jal = 0; e_dout = 0; e_rd = 0; e_dwe = 0; e_daddr = 0; e_dbe = 0; e_dwdata = 0;
    chk_dmem = 1; chk_wd = 1;
    $display("txn reset cycles=%0d", n);
  endtask

  task automatic alu_op(input logic [2:0] f3, input logic we, input logic [31:0] jal,
                        input logic [4:0] rd, input logic ack);
    EX_FUNC3 = f3; EX_WRITE_ENABLE = we; EX_DATA_MEM_SELECT = 0; EX_MEM_WRITE = 0;
    EX_ALU_RESULT = 32'h0000_0FFF; EX_JAL_SELECTED = jal; EX_RS2_DATA = 32'h5A5A_5A5A;
    EX_RD = rd; DMEM_ACK = ack;
    @(posedge CLK); #1;
    DMEM_ACK = 0;
    e_func3 = f3; e_wen = we; e_dsel = 0; e_jal = jal; e_rd = rd; e_dout = m_dout; e_fault = 0;
    set_idle();
    $display("txn alu rd=%0d we=%0b val=%h ack=%0b", rd, we, jal, ack);
  endtask

  task automatic mem_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] rs2, input logic we,
                        input logic [4:0] rd, input logic [31:0] rdata, input int wait_n,
                        input bit never_ack);
    logic acked;
    EX_FUNC3 = f3; EX_WRITE_ENABLE = we; EX_DATA_MEM_SELECT = ld; EX_MEM_WRITE = st;
    EX_ALU_RESULT = a; EX_JAL_SELECTED = ~a; EX_RS2_DATA = rs2; EX_RD = rd;
    DMEM_RDATA = rdata; DMEM_ACK = 0;
    @(posedge CLK); #1;
    e_func3 = f3; e_dsel = ld; e_jal = ~a; e_rd = rd; e_wen = 0; e_dout = m_dout;
    busy_n = 0;
    if (mis(f3, a)) begin
      e_fault = 1;
      set_idle();
      $display("txn %s addr=%h misaligned", tag, a);
      return;
    end
    e_fault = 0; e_stall = 1; e_req = 1;
    chk_dmem = 1; chk_wd = st;
    e_dwe = st; e_daddr = {a[31:2], 2'b00}; e_dbe = mbe(f3, a); e_dwdata = mwd(f3, rs2);
    sn_addr = DMEM_ADDR; sn_be = DMEM_BE; sn_wd = DMEM_WDATA; sn_we = DMEM_WE;
    for (int i = 0; i < TO; i++) begin
      busy_n += int'(DMEM_REQ);
      acked = !never_ack && (i == wait_n);
      DMEM_ACK = acked;
      @(posedge CLK); #1;
      DMEM_ACK = 0;
      if (acked) begin
        e_wen = we;
        if (ld && !st) m_dout = rdata >> (8 * int'(a[1:0]));
        e_dout = m_dout;
        set_idle();
        break;
      end
      if (i == TO - 1) begin
        e_fault = 1;
        set_idle();
      end
    end
    $display("txn %s addr=%h busy=%0d dout=%h", tag, a, busy_n, m_dout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);
    chk_en = 1;
    check("lit_rst_req", {31'b0, DMEM_REQ}, 32'd0);

    alu_op(3'b000, 1'b1, 32'h1234_5678, 5'd3, 1'b0);
    check("lit_alu_jal", MEM_JAL_SELECTED, 32'h1234_5678);
    check("lit_alu_rd", {27'b0, MEM_RD}, 32'd3);
    check("lit_alu_wen", {31'b0, MEM_WRITE_ENABLE}, 32'd1);
    check("lit_alu_stall", {31'b0, MEM_STALL}, 32'd0);

    mem_op("LB", 1, 0, 3'b000, 32'h102, 32'h0, 1, 5'd5, 32'h11FA_2233, 2, 0);
    check("lit_lb_addr", sn_addr, 32'h100);
    check("lit_lb_be", {28'b0, sn_be}, 32'b0100);
    check("lit_lb_busy", busy_n, 32'd3);
    check("lit_lb_dout", MEM_DATA_OUT, 32'h0000_11FA);
    check("lit_lb_dsel", {31'b0, MEM_DATA_MEM_SELECT}, 32'd1);
    check("lit_lb_wen", {31'b0, MEM_WRITE_ENABLE}, 32'd1);

    mem_op("SH", 0, 1, 3'b001, 32'h202, 32'hABCD_BEEF, 0, 5'd0, 32'h0, 0, 0);
    check("lit_sh_we", {31'b0, sn_we}, 32'd1);
    check("lit_sh_be", {28'b0, sn_be}, 32'b1100);
    check("lit_sh_wd", sn_wd, 32'hBEEF_BEEF);
    check("lit_sh_addr", sn_addr, 32'h200);
    check("lit_sh_wen", {31'b0, MEM_WRITE_ENABLE}, 32'd0);

    mem_op("LW_mis", 1, 0, 3'b010, 32'h001, 32'h0, 1, 5'd9, 32'h0, 0, 0);
    check("lit_mis_fault", {31'b0, MEM_FAULT}, 32'd1);
    check("lit_mis_req", {31'b0, DMEM_REQ}, 32'd0);
    check("lit_mis_wen", {31'b0, MEM_WRITE_ENABLE}, 32'd0);

    alu_op(3'b111, 1'b0, 32'hCAFE_0001, 5'd31, 1'b0);
    mem_op("LHU", 1, 0, 3'b101, 32'h306, 32'h0, 1, 5'd6, 32'hCAFE_1234, 1, 0);
    mem_op("LBU", 1, 0, 3'b100, 32'h401, 32'h0, 1, 5'd7, 32'h00AB_5500, 0, 0);
    mem_op("SB", 0, 1, 3'b000, 32'h503, 32'h0000_00A5, 0, 5'd0, 32'h0, 0, 0);
    mem_op("SW", 0, 1, 3'b010, 32'h600, 32'h0102_0304, 0, 5'd0, 32'h0, 3, 0);
    mem_op("SH_mis", 0, 1, 3'b001, 32'h201, 32'h1111_2222, 0, 5'd0, 32'h0, 0, 0);
    mem_op("LH", 1, 0, 3'b001, 32'h102, 32'h0, 1, 5'd8, 32'h8001_7FFE, 0, 0);
    check("lit_lh_dout", MEM_DATA_OUT, 32'h0000_8001);
    mem_op("SW_mis", 0, 1, 3'b010, 32'h602, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    mem_op("LB3", 1, 0, 3'b000, 32'h003, 32'h0, 1, 5'd10, 32'h7700_0000, 0, 0);
    mem_op("LW_last", 1, 0, 3'b010, 32'h700, 32'h0, 1, 5'd11, 32'hDEAD_BEEF, TO - 1, 0);
    check("lit_last_fault", {31'b0, MEM_FAULT}, 32'd0);
    check("lit_last_busy", busy_n, TO);

    mem_op("LW_to", 1, 0, 3'b010, 32'h40, 32'h0, 1, 5'd12, 32'h0, 0, 1);
    check("lit_to_busy", busy_n, TO);
    check("lit_to_fault", {31'b0, MEM_FAULT}, 32'd1);
    check("lit_to_wen", {31'b0, MEM_WRITE_ENABLE}, 32'd0);
    alu_op(3'b000, 1'b1, 32'h0000_55AA, 5'd7, 1'b0);
    check("lit_after_to", MEM_JAL_SELECTED, 32'h0000_55AA);

    // Abort an access with reset while busy
    EX_FUNC3 = 3'b010; EX_WRITE_ENABLE = 1; EX_DATA_MEM_SELECT = 1; EX_MEM_WRITE = 0;
    EX_ALU_RESULT = 32'h80; EX_JAL_SELECTED = 32'h1; EX_RD = 5'd13; DMEM_ACK = 0;
    @(posedge CLK); #1;
    e_func3 = 3'b010; e_dsel = 1; e_jal = 32'h1; e_rd = 5'd13; e_wen = 0; e_fault = 0;
    e_dout = m_dout; e_stall = 1; e_req = 1; chk_dmem = 1; chk_wd = 0;
    e_dwe = 0; e_daddr = 32'h80; e_dbe = 4'b1111;
    @(posedge CLK); #1;
    do_reset(1);
    check("lit_abort_req", {31'b0, DMEM_REQ}, 32'd0);
    check("lit_abort_rd", {27'b0, MEM_RD}, 32'd0);
    check("lit_abort_dout", MEM_DATA_OUT, 32'd0);
    alu_op(3'b000, 1'b0, 32'h0, 5'd0, 1'b1);
    check("lit_late_ack_wen", {31'b0, MEM_WRITE_ENABLE}, 32'd0);
    alu_op(3'b000, 1'b1, 32'hFFFF_0000, 5'd1, 1'b0);

    @(negedge CLK);
    #1;
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the RV32IM core: sits between the EX stage and the WB stage. It registers EX results, performs data-memory loads and stores over a req/ack handshake, and stalls upstream until each access completes. It presents load data to WB with the addressed byte or halfword already shifted to bit 0; WB's load processing does sign/zero extension.

## Interface
Parameters:
- ACK_TIMEOUT, 16: maximum BUSY cycles waited for DMEM_ACK before the access is aborted.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- EX_FUNC3  in  3  load/store width: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- EX_WRITE_ENABLE  in  1  register-file write request.
- EX_DATA_MEM_SELECT  in  1  instruction is a load.
- EX_MEM_WRITE  in  1  instruction is a store.
- EX_ALU_RESULT  in  32  effective address for loads and stores.
- EX_JAL_SELECTED  in  32  non-memory writeback value (ALU result or PC+4).
- EX_RS2_DATA  in  32  store data.
- EX_RD  in  5  destination register.
- DMEM_RDATA  in  32  memory read word.
- DMEM_ACK  in  1  memory completes the current request.
- MEM_STALL  out  1  upstream holds EX_* stable and does not advance.
- DMEM_REQ, DMEM_WE  out  1 each  request valid; write (1) or read (0).
- DMEM_ADDR  out  32  word address: {addr[31:2], 2'b00}.
- DMEM_BE  out  4  byte enables.
- DMEM_WDATA  out  32  lane-replicated store data.
- MEM_FUNC3, MEM_WRITE_ENABLE, MEM_DATA_MEM_SELECT, MEM_JAL_SELECTED, MEM_DATA_OUT, MEM_RD  out  3/1/1/32/32/5  registered outputs to WB.
- MEM_FAULT  out  1  one-cycle pulse on a misaligned access or an ack timeout.

## Operation
- FSM states: IDLE and BUSY. MEM_STALL = DMEM_REQ = (state==BUSY). DMEM_WE, DMEM_ADDR, DMEM_BE and DMEM_WDATA are registered and held constant throughout BUSY.
- IDLE, every edge:
  - Capture EX_FUNC3, EX_DATA_MEM_SELECT, EX_JAL_SELECTED and EX_RD into the MEM_* outputs.
  - Memory op = EX_DATA_MEM_SELECT | EX_MEM_WRITE.
  - Non-memory op: MEM_WRITE_ENABLE <= EX_WRITE_ENABLE; stay in IDLE.
- Misalignment rules:
  - H/HU/SH (func3[1:0]=01) is misaligned when addr[0]=1.
  - W/SW is misaligned when addr[1:0]≠0.
  - Byte accesses are never misaligned.
- Misaligned memory op: MEM_FAULT <= 1, MEM_WRITE_ENABLE <= 0, no request issued; stay in IDLE.
- Aligned memory op: MEM_WRITE_ENABLE <= 0; save pending_we = EX_WRITE_ENABLE; clear the timeout counter; go to BUSY.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 << addr[1:0].
  - W: 4'b1111.
- Store data: B gives {4{rs2[7:0]}}; H gives {2{rs2[15:0]}}; W gives rs2.
- BUSY, DMEM_ACK=1:
  - Loads: MEM_DATA_OUT <= DMEM_RDATA >> (8*addr[1:0]).
  - MEM_WRITE_ENABLE <= pending_we.
  - Go to IDLE.
- BUSY, no ack: the counter increments. When the counter reaches ACK_TIMEOUT-1 without an ack: MEM_FAULT <= 1, MEM_WRITE_ENABLE <= 0, go to IDLE.
- MEM_DATA_OUT keeps its previous value on non-load instructions.
- DMEM_ACK arriving in IDLE is ignored.
- MEM_FAULT is 0 on every edge not listed above.

## Timing
- Reset values: state IDLE, every MEM_* output 0, MEM_FAULT 0, DMEM_WE/ADDR/BE/WDATA 0, counter 0. DMEM_REQ and MEM_STALL are therefore 0.
- Reset during BUSY: the next edge returns to IDLE. The aborted access produces no writeback and no fault.
- Non-memory instruction: 1-cycle latency EX to MEM_*; no stall.
- Memory access:
  - The capture edge asserts DMEM_REQ in the next cycle.
  - A same-cycle ack gives MEM_WRITE_ENABLE=1 after the second edge.
  - Minimum occupancy is 2 cycles; each wait cycle adds one.
- MEM_STALL is high during every BUSY cycle, including the ack cycle. The following instruction is captured on the first IDLE edge after BUSY.
- MEM_WRITE_ENABLE is 0 for every BUSY cycle, so WB never writes a stale value.

## Test plan
- ALU op, EX_WRITE_ENABLE=1, EX_JAL_SELECTED=0x12345678, EX_RD=3 -> next cycle MEM_JAL_SELECTED=0x12345678, MEM_RD=3, MEM_WRITE_ENABLE=1, MEM_STALL=0.
- LB at addr 0x102, DMEM_RDATA=0x11FA2233, ack 2 cycles after DMEM_REQ rises -> DMEM_ADDR=0x100, DMEM_BE=0100, stall high for 3 cycles, then MEM_DATA_OUT=0x000011FA, MEM_DATA_MEM_SELECT=1, MEM_WRITE_ENABLE=1.
- SH at addr 0x202, rs2=0xABCDBEEF, immediate ack -> DMEM_WE=1, DMEM_BE=1100, DMEM_WDATA=0xBEEFBEEF, DMEM_ADDR=0x200, MEM_WRITE_ENABLE=0.
- LW at 0x001 -> MEM_FAULT pulses for 1 cycle, DMEM_REQ never asserts, MEM_WRITE_ENABLE=0.
- LW at 0x40 with no ack -> BUSY for ACK_TIMEOUT cycles, then MEM_FAULT=1 and IDLE; a subsequent ALU op passes normally.
- RST asserted mid-BUSY -> after the next edge DMEM_REQ=0, MEM_STALL=0, all MEM_* outputs 0; a late ack is ignored.
